// File: rtl/ibex_pkg.sv
// Shared types and constants for the instruction realigner slice.
//   realign_state_e : realigner FSM states
//   OPCODE_*        : RV32 major opcodes produced by the compressed decoder
//   is_compressed() : true when a 16-bit parcel starts a compressed instruction
package ibex_pkg;

  typedef enum logic [1:0] {
    RA_ALIGNED = 2'd0,
    RA_RESID   = 2'd1,
    RA_SKIP    = 2'd2
  } realign_state_e;

  localparam logic [6:0] OPCODE_LOAD   = 7'h03;
  localparam logic [6:0] OPCODE_OP_IMM = 7'h13;
  localparam logic [6:0] OPCODE_STORE  = 7'h23;
  localparam logic [6:0] OPCODE_OP     = 7'h33;
  localparam logic [6:0] OPCODE_LUI    = 7'h37;
  localparam logic [6:0] OPCODE_BRANCH = 7'h63;
  localparam logic [6:0] OPCODE_JALR   = 7'h67;
  localparam logic [6:0] OPCODE_JAL    = 7'h6f;

  function automatic logic is_compressed(input logic [15:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/ibex_instr_realigner_if.sv
// Fetch-side, branch and instruction-side signals of the realigner.
//   master : the realigner (consumes fetch words, produces instructions)
//   slave  : the environment (fetch source, branch source, decode stage)
interface ibex_instr_realigner_if;
  logic        fetch_valid_i;
  logic [31:0] fetch_rdata_i;
  logic        fetch_ready_o;
  logic        branch_i;
  logic [31:0] branch_addr_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_raw_o;
  logic        is_compressed_o;
  logic        illegal_c_o;
  logic [31:0] pc_o;

  modport master (
    input  fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, instr_ready_i,
    output fetch_ready_o, instr_valid_o, instr_o, instr_raw_o, is_compressed_o,
           illegal_c_o, pc_o
  );

  modport slave (
    output fetch_valid_i, fetch_rdata_i, branch_i, branch_addr_i, instr_ready_i,
    input  fetch_ready_o, instr_valid_o, instr_o, instr_raw_o, is_compressed_o,
           illegal_c_o, pc_o
  );
endinterface

// File: rtl/ibex_compressed_decoder.sv
// Combinational RV32C -> RV32I expander.
//   clk_i, rst_ni   : used only by the embedded assertion
//   valid_i         : instr_i carries a real instruction (assertion only)
//   instr_i         : raw instruction, compressed ones in [15:0]
//   instr_o         : expanded 32-bit instruction (instr_i when not compressed)
//   is_compressed_o : instr_i[1:0] != 2'b11
//   illegal_instr_o : compressed encoding is not a legal RV32C instruction
module ibex_compressed_decoder
  import ibex_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        valid_i,
  input  logic [31:0] instr_i,
  output logic [31:0] instr_o,
  output logic        is_compressed_o,
  output logic        illegal_instr_o
);

  always_comb begin
    instr_o         = instr_i;
    illegal_instr_o = 1'b0;

    case (instr_i[1:0])
      2'b00: begin
        case (instr_i[15:13])
          3'b000: begin  // c.addi4spn
            instr_o = {2'b0, instr_i[10:7], instr_i[12:11], instr_i[5], instr_i[6], 2'b00,
                       5'h02, 3'b000, 2'b01, instr_i[4:2], OPCODE_OP_IMM};
            if (instr_i[12:5] == 8'b0) illegal_instr_o = 1'b1;
          end
          3'b010: begin  // c.lw
            instr_o = {5'b0, instr_i[5], instr_i[12:10], instr_i[6], 2'b00, 2'b01,
                       instr_i[9:7], 3'b010, 2'b01, instr_i[4:2], OPCODE_LOAD};
          end
          3'b110: begin  // c.sw
            instr_o = {5'b0, instr_i[5], instr_i[12], 2'b01, instr_i[4:2], 2'b01,
                       instr_i[9:7], 3'b010, instr_i[11:10], instr_i[6], 2'b00, OPCODE_STORE};
          end
          default: illegal_instr_o = 1'b1;
        endcase
      end

      2'b01: begin
        case (instr_i[15:13])
          3'b000: begin  // c.addi
            instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], instr_i[11:7], 3'b000,
                       instr_i[11:7], OPCODE_OP_IMM};
          end
          3'b001, 3'b101: begin  // c.jal (rd=x1) / c.j (rd=x0)
            instr_o = {instr_i[12], instr_i[8], instr_i[10:9], instr_i[6], instr_i[7],
                       instr_i[2], instr_i[11], instr_i[5:3], {9{instr_i[12]}}, 4'b0,
                       ~instr_i[15], OPCODE_JAL};
          end
          3'b010: begin  // c.li
            instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 5'b0, 3'b000,
                       instr_i[11:7], OPCODE_OP_IMM};
          end
          3'b011: begin
            if (instr_i[11:7] == 5'h02) begin  // c.addi16sp
              instr_o = {{3{instr_i[12]}}, instr_i[4:3], instr_i[5], instr_i[2], instr_i[6],
                         4'b0, 5'h02, 3'b000, 5'h02, OPCODE_OP_IMM};
            end else begin  // c.lui
              instr_o = {{15{instr_i[12]}}, instr_i[6:2], instr_i[11:7], OPCODE_LUI};
            end
            if ({instr_i[12], instr_i[6:2]} == 6'b0) illegal_instr_o = 1'b1;
          end
          3'b100: begin
            case (instr_i[11:10])
              2'b00, 2'b01: begin  // c.srli / c.srai
                instr_o = {1'b0, instr_i[10], 5'b0, instr_i[6:2], 2'b01, instr_i[9:7],
                           3'b101, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
                if (instr_i[12]) illegal_instr_o = 1'b1;
              end
              2'b10: begin  // c.andi
                instr_o = {{6{instr_i[12]}}, instr_i[12], instr_i[6:2], 2'b01, instr_i[9:7],
                           3'b111, 2'b01, instr_i[9:7], OPCODE_OP_IMM};
              end
              default: begin
                case ({instr_i[12], instr_i[6:5]})
                  3'b000: instr_o = {2'b01, 5'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                     3'b000, 2'b01, instr_i[9:7], OPCODE_OP};  // c.sub
                  3'b001: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                     3'b100, 2'b01, instr_i[9:7], OPCODE_OP};  // c.xor
                  3'b010: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                     3'b110, 2'b01, instr_i[9:7], OPCODE_OP};  // c.or
                  3'b011: instr_o = {7'b0, 2'b01, instr_i[4:2], 2'b01, instr_i[9:7],
                                     3'b111, 2'b01, instr_i[9:7], OPCODE_OP};  // c.and
                  default: illegal_instr_o = 1'b1;
                endcase
              end
            endcase
          end
          default: begin  // c.beqz / c.bnez
            instr_o = {{4{instr_i[12]}}, instr_i[6:5], instr_i[2], 5'b0, 2'b01, instr_i[9:7],
                       2'b00, instr_i[13], instr_i[11:10], instr_i[4:3], instr_i[12],
                       OPCODE_BRANCH};
          end
        endcase
      end

      2'b10: begin
        case (instr_i[15:13])
          3'b000: begin  // c.slli
            instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b001, instr_i[11:7], OPCODE_OP_IMM};
            if (instr_i[12]) illegal_instr_o = 1'b1;
          end
          3'b010: begin  // c.lwsp
            instr_o = {4'b0, instr_i[3:2], instr_i[12], instr_i[6:4], 2'b00, 5'h02, 3'b010,
                       instr_i[11:7], OPCODE_LOAD};
            if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
          end
          3'b100: begin
            if (!instr_i[12]) begin
              if (instr_i[6:2] != 5'b0) begin  // c.mv
                instr_o = {7'b0, instr_i[6:2], 5'b0, 3'b000, instr_i[11:7], OPCODE_OP};
              end else begin  // c.jr
                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b0, OPCODE_JALR};
                if (instr_i[11:7] == 5'b0) illegal_instr_o = 1'b1;
              end
            end else begin
              if (instr_i[6:2] != 5'b0) begin  // c.add
                instr_o = {7'b0, instr_i[6:2], instr_i[11:7], 3'b000, instr_i[11:7], OPCODE_OP};
              end else if (instr_i[11:7] == 5'b0) begin  // c.ebreak
                instr_o = 32'h0010_0073;
              end else begin  // c.jalr
                instr_o = {12'b0, instr_i[11:7], 3'b000, 5'b00001, OPCODE_JALR};
              end
            end
          end
          3'b110: begin  // c.swsp
            instr_o = {4'b0, instr_i[8:7], instr_i[12], instr_i[6:2], 5'h02, 3'b010,
                       instr_i[11:9], 2'b00, OPCODE_STORE};
          end
          default: illegal_instr_o = 1'b1;
        endcase
      end

      default: ;  // 32-bit instruction passes through
    endcase
  end

  assign is_compressed_o = instr_i[1:0] != 2'b11;

  valid_known_a : assert property (@(posedge clk_i) disable iff (!rst_ni)
      valid_i |-> !$isunknown(instr_i));

endmodule

// File: rtl/ibex_instr_realigner.sv
// Realigns a stream of word-aligned fetch words into RV32/RV32C instructions
// and expands compressed ones. Zero-latency: outputs are a combinational
// function of the current state and the fetch word.
//   clk_i, rst_i         : clock, synchronous active-high reset
//   bus.fetch_*          : fetch word handshake (words in ascending address order)
//   bus.branch_i/_addr_i : redirect pulse and target (bit 0 ignored)
//   bus.instr_*          : instruction handshake, expanded and raw forms
//   bus.is_compressed_o  : output instruction is 16-bit
//   bus.illegal_c_o      : illegal compressed encoding
//   bus.pc_o             : address of the output instruction
module ibex_instr_realigner
  import ibex_pkg::*;
#(
  parameter logic [31:0] BootAddr = 32'h0000_0080
) (
  input logic                    clk_i,
  input logic                    rst_i,
  ibex_instr_realigner_if.master bus
);

  realign_state_e state_q;
  logic [15:0]    residue_q;
  logic [31:0]    pc_q;

  logic [31:0] raw_instr;
  logic        instr_valid;
  logic        fetch_ready;
  logic        raw_compressed;
  logic        out_fire;
  logic        fetch_fire;

  logic [31:0] dec_instr;
  logic        dec_compressed;
  logic        dec_illegal;

  // Only the halfword granularity of the target matters.
  logic unused_branch_addr_bit0;
  assign unused_branch_addr_bit0 = bus.branch_addr_i[0];

  always_comb begin
    raw_instr   = bus.fetch_rdata_i;
    instr_valid = 1'b0;
    fetch_ready = 1'b0;
    case (state_q)
      RA_ALIGNED: begin
        if (is_compressed(bus.fetch_rdata_i[15:0])) begin
          raw_instr = {16'h0000, bus.fetch_rdata_i[15:0]};
        end
        instr_valid = bus.fetch_valid_i;
        fetch_ready = bus.instr_ready_i;
      end
      RA_RESID: begin
        if (is_compressed(residue_q)) begin
          // Residue is a whole instruction; no fetch word needed.
          raw_instr   = {16'h0000, residue_q};
          instr_valid = 1'b1;
        end else begin
          // 32-bit instruction straddling two fetch words.
          raw_instr   = {bus.fetch_rdata_i[15:0], residue_q};
          instr_valid = bus.fetch_valid_i;
          fetch_ready = bus.instr_ready_i;
        end
      end
      RA_SKIP: fetch_ready = 1'b1;
      default: ;
    endcase
    if (rst_i || bus.branch_i) begin
      instr_valid = 1'b0;
      fetch_ready = 1'b0;
    end
  end

  assign raw_compressed = is_compressed(raw_instr[15:0]);
  assign out_fire       = instr_valid & bus.instr_ready_i;
  assign fetch_fire     = fetch_ready & bus.fetch_valid_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= RA_ALIGNED;
      residue_q <= 16'h0000;
      pc_q      <= BootAddr;
    end else if (bus.branch_i) begin
      pc_q      <= {bus.branch_addr_i[31:1], 1'b0};
      residue_q <= 16'h0000;
      // An odd-halfword target discards the lower half of the first word.
      state_q   <= bus.branch_addr_i[1] ? RA_SKIP : RA_ALIGNED;
    end else begin
      case (state_q)
        RA_ALIGNED: begin
          if (out_fire) begin
            if (raw_compressed) begin
              residue_q <= bus.fetch_rdata_i[31:16];
              pc_q      <= pc_q + 32'd2;
              state_q   <= RA_RESID;
            end else begin
              pc_q      <= pc_q + 32'd4;
            end
          end
        end
        RA_RESID: begin
          if (out_fire) begin
            if (raw_compressed) begin
              pc_q      <= pc_q + 32'd2;
              state_q   <= RA_ALIGNED;
            end else begin
              residue_q <= bus.fetch_rdata_i[31:16];
              pc_q      <= pc_q + 32'd4;
            end
          end
        end
        RA_SKIP: begin
          if (fetch_fire) begin
            residue_q <= bus.fetch_rdata_i[31:16];
            state_q   <= RA_RESID;
          end
        end
        default: state_q <= RA_ALIGNED;
      endcase
    end
  end

  ibex_compressed_decoder u_compressed_decoder (
    .clk_i           (clk_i),
    .rst_ni          (~rst_i),
    .valid_i         (instr_valid),
    .instr_i         (raw_instr),
    .instr_o         (dec_instr),
    .is_compressed_o (dec_compressed),
    .illegal_instr_o (dec_illegal)
  );

  assign bus.fetch_ready_o   = fetch_ready;
  assign bus.instr_valid_o   = instr_valid;
  assign bus.instr_o         = dec_instr;
  assign bus.instr_raw_o     = raw_instr;
  assign bus.is_compressed_o = dec_compressed;
  assign bus.illegal_c_o     = dec_compressed & dec_illegal;
  assign bus.pc_o            = pc_q;

endmodule

// File: doc/ibex_instr_realigner.md
IBEX_INSTR_REALIGNER -- requirements
Module: ibex_instr_realigner

Interface
REQ-001 The module SHALL have parameter BootAddr, default 32'h0000_0080, the first fetch PC after reset, word aligned.
REQ-002 The module SHALL have port clk_i, input, 1 bit, the single clock.
REQ-003 The module SHALL have port rst_i, input, 1 bit, a synchronous, active-high reset sampled on the rising edge of clk_i.
REQ-004 The module SHALL have port fetch_valid_i, input, 1 bit, which marks fetch_rdata_i as valid.
REQ-005 The module SHALL have port fetch_rdata_i, input, 32 bits, one word-aligned fetch word, with fetch words in ascending address order.
REQ-006 The module SHALL have port fetch_ready_o, output, 1 bit; a fetch word is consumed when fetch_valid_i and fetch_ready_o are both 1.
REQ-007 The module SHALL have port branch_i, input, 1 bit, a redirect pulse; the fetch source flushes in the same cycle.
REQ-008 The module SHALL have port branch_addr_i, input, 32 bits, the redirect target; bit 0 is ignored.
REQ-009 The module SHALL have port instr_valid_o, output, 1 bit, which marks the output instruction as valid.
REQ-010 The module SHALL have port instr_ready_i, input, 1 bit; the output instruction is accepted when instr_valid_o and instr_ready_i are both 1.
REQ-011 The module SHALL have port instr_o, output, 32 bits, the expanded RV32 instruction.
REQ-012 The module SHALL have port instr_raw_o, output, 32 bits, the raw instruction; a compressed instruction is zero-extended from 16 bits.
REQ-013 The module SHALL have port is_compressed_o, output, 1 bit, set when the output instruction is 16-bit.
REQ-014 The module SHALL have port illegal_c_o, output, 1 bit, which is the decoder illegal flag when is_compressed_o is 1 and 0 otherwise.
REQ-015 The module SHALL have port pc_o, output, 32 bits, the address of the output instruction.

Function
REQ-016 The module SHALL hold state as follows:
- a state register: ALIGNED, RESID or SKIP;
- a 16-bit residue register holding the upper half of a partly used fetch word;
- a 32-bit pc register with bit 0 always 0.
REQ-017 In ALIGNED with fetch_valid_i=1 and fetch_rdata_i[1:0]==11, the raw instruction SHALL be fetch_rdata_i; fetch_ready_o=instr_ready_i; on acceptance, pc+=4 and the state stays ALIGNED.
REQ-018 In ALIGNED with fetch_valid_i=1 and fetch_rdata_i[1:0]!=11, the raw instruction SHALL be fetch_rdata_i[15:0]; on acceptance:
- the fetch word is consumed;
- residue<=fetch_rdata_i[31:16];
- pc+=2;
- state goes to RESID.
REQ-019 In RESID with residue[1:0]!=11, the raw instruction SHALL be the residue, with instr_valid_o=1 independent of fetch_valid_i and fetch_ready_o=0; on acceptance, pc+=2 and state goes to ALIGNED.
REQ-020 In RESID with residue[1:0]==11, the raw instruction SHALL be {fetch_rdata_i[15:0], residue}, with instr_valid_o=fetch_valid_i; on acceptance:
- the fetch word is consumed;
- residue<=fetch_rdata_i[31:16];
- pc+=4;
- state stays RESID.
REQ-021 In SKIP, instr_valid_o SHALL be 0 and fetch_ready_o SHALL be 1; on a fetch handshake, residue<=fetch_rdata_i[31:16], pc is unchanged, and state goes to RESID.
REQ-022 instr_valid_o SHALL be 0 in ALIGNED when fetch_valid_i=0.
REQ-023 While instr_valid_o=1 and instr_ready_i=0, instr_o, instr_raw_o, pc_o and the state SHALL hold stable.
REQ-024 The raw instruction SHALL pass through one combinational ibex_compressed_decoder to produce instr_o, with is_compressed_o=(raw[1:0]!=11).
REQ-025 Output latency SHALL be zero cycles: fetch to instr_valid_o is combinational fall-through, and state updates on the handshake edge.
REQ-026 branch_i SHALL have priority over all other events in its cycle:
- instr_valid_o=0 and fetch_ready_o=0;
- any pending handshake is discarded;
- next cycle pc={branch_addr_i[31:1],1'b0} and residue is cleared;
- state becomes SKIP if branch_addr_i[1]==1, else ALIGNED.
REQ-027 A branch while the output is stalled (valid=1, ready=0) SHALL drop the stalled instruction without emitting it.
REQ-028 pc SHALL wrap modulo 2^32 (0xFFFF_FFFE+2 -> 0x0000_0000).
REQ-029 Successive branch_i pulses SHALL each retarget; the last one wins.

Reset
REQ-030 On rst_i=1 at a clock edge, the module SHALL set state=ALIGNED, pc=BootAddr and residue=16'h0000.
REQ-031 While rst_i=1, the module SHALL drive instr_valid_o=0 and fetch_ready_o=0, and all in-flight data SHALL be lost.
REQ-032 rst_i SHALL override branch_i in the same cycle.

Structure
REQ-033 The enum type realign_state_e (RA_ALIGNED, RA_RESID, RA_SKIP) SHALL be defined in ibex_pkg.
REQ-034 The module SHALL instantiate exactly one ibex_compressed_decoder, with its assertion-only reset port tied to ~rst_i.
REQ-035 The module SHALL contain no other sub-modules and no storage beyond REQ-016.

Verification
REQ-036 The bench SHALL check that after reset, fetch word 0x00A00093 yields instr_o=0x00A00093, pc_o=0x80, is_compressed_o=0, and next pc 0x84.
REQ-037 The bench SHALL check that fetch word 0x4505_4585 yields instr_o=0x00100593 at pc 0x80 with the fetch consumed, then instr_o=0x00100513 at pc 0x82 with fetch_ready_o=0.
REQ-038 The bench SHALL check the straddle case: words 0x0093_4585 then 0x1234_00A0 yield 0x00100593 at 0x80, then 0x00A00093 at 0x82, with residue 0x1234 afterwards.
REQ-039 The bench SHALL check that branch_i with target 0x102, followed by word 0x4505_0001, drops the low half and yields 0x00100513 at pc 0x102.
REQ-040 The bench SHALL check that branch_i to 0x200 during an output stall (instr_ready_i=0) never emits the stalled instruction, and that the next output has pc_o=0x200.
REQ-041 The bench SHALL check that residue 0x0000 yields illegal_c_o=1 and is_compressed_o=1, and that a reset asserted mid-stall returns pc_o to 0x80.
